// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants for the RV32M multiply/divide unit
//
// Contents:
//   XLEN_DEFAULT       default operand/result width
//   F3_MUL..F3_REMU    RV32M funct3 opcodes
//   S_IDLE..S_DONE     FSM state encoding
//   op1_signed/op2_signed  which operands an opcode treats as two's complement

package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // MUL only uses the low half of the product, which is identical for
  // signed and unsigned operands, so it is treated as unsigned.
  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// rtl/muldiv_abs.sv - conditional two's-complement negate
//
// Ports:
//   value  in   W   operand
//   neg    in   1   1 = negate, 0 = pass through
//   res    out  W   value or -value

module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Ports:
//   clk     in   1     clock, rising edge
//   rst     in   1     synchronous active-high reset
//   start   in   1     request, taken when ready=1
//   flush   in   1     abort in-flight op
//   funct3  in   3     RV32M opcode
//   op1     in   XLEN  rs1 (multiplicand / dividend)
//   op2     in   XLEN  rs2 (multiplier / divisor)
//   ready   out  1     can accept start (IDLE or DONE)
//   busy    out  1     op in flight (CALC or FIX)
//   done    out  1     one-cycle result-valid pulse
//   result  out  XLEN  last completed result

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [1:0]      state;
  logic [5:0]      cnt;
  logic [2:0]      f3_r;
  // acc: upper product half (plus carry) for multiply, partial remainder for divide.
  // mq:  multiplier shifting out / dividend shifting out and quotient shifting in.
  logic [XLEN:0]   acc;
  logic [XLEN-1:0] mq;
  logic [XLEN-1:0] b;
  logic            neg_res;

  assign ready = (state == S_IDLE) || (state == S_DONE);
  assign busy  = (state == S_CALC) || (state == S_FIX);

  // ---------------- accept-side decode ----------------
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;
  logic            neg_next;
  logic            is_rem_in;

  assign s1 = op1_signed(funct3) & op1[XLEN-1];
  assign s2 = op2_signed(funct3) & op2[XLEN-1];

  muldiv_abs #(.W(XLEN)) u_abs_op1 (.value(op1), .neg(s1), .res(mag1));
  muldiv_abs #(.W(XLEN)) u_abs_op2 (.value(op2), .neg(s2), .res(mag2));

  assign is_rem_in = (funct3 == F3_REM) || (funct3 == F3_REMU);
  assign div_zero  = funct3[2] && (op2 == '0);
  assign div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  assign special   = div_zero || div_ovf;

  // Remainder follows the dividend's sign; product and quotient are negative
  // when the operand signs differ.
  assign neg_next  = is_rem_in ? s1 : (s1 ^ s2);

  always_comb begin
    special_val = '0;
    if (div_zero) begin
      special_val = is_rem_in ? op1 : '1;
    end else if (div_ovf) begin
      special_val = is_rem_in ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // ---------------- iteration datapath ----------------
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;
  logic          div_ok;

  assign mul_sum   = acc + {1'b0, (mq[0] ? b : {XLEN{1'b0}})};
  assign div_shift = {acc[XLEN-1:0], mq[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b};
  assign div_ok    = ~div_diff[XLEN];

  // ---------------- sign correction ----------------
  logic [2*XLEN-1:0] fix_raw, fix_val;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    fix_raw = '0;
    case (f3_r)
      F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU: fix_raw = {acc[XLEN-1:0], mq};
      F3_DIV, F3_DIVU:                      fix_raw = {{XLEN{1'b0}}, mq};
      F3_REM, F3_REMU:                      fix_raw = {{XLEN{1'b0}}, acc[XLEN-1:0]};
      default:                              fix_raw = '0;
    endcase
  end

  // Negate the full double-width value so a high-half result sees the
  // borrow out of the low half.
  muldiv_abs #(.W(2*XLEN)) u_abs_fix (.value(fix_raw), .neg(neg_res), .res(fix_val));

  always_comb begin
    fix_res = fix_val[XLEN-1:0];
    if ((f3_r == F3_MULH) || (f3_r == F3_MULHSU) || (f3_r == F3_MULHU)) begin
      fix_res = fix_val[2*XLEN-1:XLEN];
    end
  end

  // ---------------- FSM and registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      f3_r    <= '0;
      acc     <= '0;
      mq      <= '0;
      b       <= '0;
      neg_res <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          // A flush on the same edge as start drops the request.
          if (start && !flush) begin
            f3_r <= funct3;
            cnt  <= '0;
            if (special) begin
              result <= special_val;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              acc     <= '0;
              mq      <= mag1;
              b       <= mag2;
              neg_res <= neg_next;
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (!f3_r[2]) begin
              // Shift-add: product bits leave acc's LSB and enter mq's MSB.
              acc <= {1'b0, mul_sum[XLEN:1]};
              mq  <= {mul_sum[0], mq[XLEN-1:1]};
            end else begin
              // Restoring divide: keep the difference only if it did not go negative.
              acc <= div_ok ? div_diff : div_shift;
              mq  <= {mq[XLEN-2:0], div_ok};
            end
            cnt <= cnt + 6'd1;
            if (cnt == 6'(XLEN-1)) begin
              state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            result <= fix_res;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
